seq_det_arb: RTL and testbench
==============================

SEQ_DET_ARB -- requirements
Module: seq_det_arb

Interface
REQ-001 Parameters SHALL be: MAXLEN, default 8, maximum pattern length in bits; CNTW, default 4, width of the per-frame match counter.
REQ-002 clk  input  1  rising-edge system clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 resets the block immediately, independent of clk.
REQ-004 cfg_we  input  1  pattern-configuration write strobe.
REQ-005 cfg_pat  input  MAXLEN  pattern; bit 0 is the most recently received bit.
REQ-006 cfg_len  input  4  pattern length.
REQ-007 req  input  2  frame request, one bit per requester.
REQ-008 gnt  output  2  one-hot registered grant.
REQ-009 bit_in  input  2  serial data bit, one per requester.
REQ-010 bit_vld  input  2  bit_in[i] is valid this cycle.
REQ-011 bit_last  input  2  the qualified bit is the last bit of requester i's frame.
REQ-012 det  output  1  Moore match flag.
REQ-013 res_vld  output  1  one-cycle frame-result strobe.
REQ-014 res_id  output  1  requester index of the reported frame.
REQ-015 res_cnt  output  CNTW  number of matches in the reported frame.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL contain a 3-state FSM: IDLE, RUN, REPORT.
REQ-018 IDLE: if req!=0, grant one requester by round-robin and go to RUN on the next edge; gnt asserts in the same edge.
REQ-019 The round-robin pointer SHALL favour the requester not served last; on simultaneous requests after reset, requester 0 wins.
REQ-020 On the IDLE->RUN edge the block SHALL clear the shift history (MAXLEN bits), the accepted-bit count and the match counter.
REQ-021 RUN: a bit SHALL be accepted only when bit_vld[sel]=1; inputs of the non-granted requester SHALL be ignored.
REQ-022 On each accepted bit: history <= {history[MAXLEN-2:0], bit_in[sel]}.
REQ-023 A match SHALL occur when both hold: the low L bits of history equal the low L bits of cfg_pat; the accepted-bit count is >= L.
REQ-024 L SHALL be the latched effective length: cfg_len clamped to 1..MAXLEN (0 becomes 1; >MAXLEN becomes MAXLEN).
REQ-025 Overlapping matches SHALL count.
REQ-026 det SHALL be registered and state-decoded: high for exactly the cycle after each edge that accepted a match-completing bit; it remains high across consecutive matching bits; it is 0 in cycles with no accepted bit.
REQ-027 The match counter SHALL increment on each match and saturate at 2^CNTW-1.
REQ-028 An accepted bit with bit_last[sel]=1 SHALL move the FSM to REPORT; that bit's match is included in the count.
REQ-029 The req level during RUN SHALL be ignored; the grant is held until bit_last.
REQ-030 REPORT: for exactly one cycle, res_vld=1, res_id=sel, res_cnt=final count; gnt=0; the round-robin pointer updates; next state is IDLE.
REQ-031 res_id and res_cnt SHALL hold their values until the next REPORT.
REQ-032 cfg_we SHALL be accepted only when busy=0 and ignored otherwise; it latches cfg_pat and the clamped cfg_len.
REQ-033 A cfg_we and a request in the same IDLE cycle SHALL both take effect; the new pattern applies to that frame.
REQ-034 bit_vld on a requester without a grant SHALL be ignored and SHALL have no side effects.

Reset
REQ-035 While reset=0, all of the following SHALL be forced asynchronously:
- state=IDLE, gnt=00, det=0, res_vld=0, res_id=0, res_cnt=0, busy=0;
- history, counters and pointer cleared (pointer favours requester 0);
- pattern = all zeros, L = 1.
REQ-036 Reset asserted mid-frame SHALL abort the frame with no res_vld; operation resumes from IDLE on the first edge after release.

Verification
REQ-037 Config pat=4'b1011, L=4; requester 0 sends 0,1,0,1,1,0,1,1,1 (last on the ninth bit) -> det high after bit 5 and bit 8; res_vld with res_id=0, res_cnt=2.
REQ-038 req=11 in IDLE after reset -> gnt=01; after frame 0 completes, with req=11 still asserted -> gnt=10.
REQ-039 pat=1, L=1; 20 consecutive 1s with CNTW=4 -> det high continuously; res_cnt saturates at 15.
REQ-040 cfg_we during RUN with a new pattern -> ignored; the frame is matched against the old pattern; busy=1 throughout.
REQ-041 reset=0 pulsed while gnt=01 mid-frame -> outputs zero immediately; no res_vld; a new req is granted normally after release.
REQ-042 cfg_len=0 then stream 1,1 with pat bit0=1 -> L=1; res_cnt=2. Toggling the non-granted requester's bit_vld has no effect on det or the count.

Source files
------------

// File: rtl/seq_det_arb_if.sv
// Signal bundle for seq_det_arb: pattern configuration, two-requester frame
// handshake, per-requester serial bit streams and the per-frame result.
interface seq_det_arb_if #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 4
);
  logic              cfg_we;
  logic [MAXLEN-1:0] cfg_pat;
  logic [3:0]        cfg_len;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [1:0]        bit_in;
  logic [1:0]        bit_vld;
  logic [1:0]        bit_last;
  logic              det;
  logic              res_vld;
  logic              res_id;
  logic [CNTW-1:0]   res_cnt;
  logic              busy;

  modport master (
    output cfg_we, cfg_pat, cfg_len, req, bit_in, bit_vld, bit_last,
    input  gnt, det, res_vld, res_id, res_cnt, busy
  );

  modport slave (
    input  cfg_we, cfg_pat, cfg_len, req, bit_in, bit_vld, bit_last,
    output gnt, det, res_vld, res_id, res_cnt, busy
  );
endinterface

// File: rtl/seq_det_arb.sv
// Two-requester round-robin arbiter feeding a serial pattern detector; the
// granted stream is matched bit by bit and a per-frame match count is reported.
module seq_det_arb #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 4
) (
  input  logic         clk,
  input  logic         reset,
  seq_det_arb_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  localparam int            LW       = $clog2(MAXLEN + 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAXLEN);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [1:0]        state_reg,   state_next;
  logic [1:0]        gnt_reg,     gnt_next;
  logic              sel_reg,     sel_next;
  logic              ptr_reg,     ptr_next;
  logic [MAXLEN-1:0] hist_reg,    hist_next;
  logic [LW-1:0]     bcnt_reg,    bcnt_next;
  logic [CNTW-1:0]   mcnt_reg,    mcnt_next;
  logic              det_reg,     det_next;
  logic              res_id_reg,  res_id_next;
  logic [CNTW-1:0]   res_cnt_reg, res_cnt_next;
  logic [MAXLEN-1:0] pat_reg,     pat_next;
  logic [LW-1:0]     len_reg,     len_next;

  logic              accept;
  logic              pick;
  logic              hit;
  logic [MAXLEN-1:0] shifted;
  logic [MAXLEN-1:0] len_mask;
  logic [LW-1:0]     bcnt_inc;
  logic [CNTW-1:0]   mcnt_inc;
  logic [LW-1:0]     len_clamped;

  // Only the granted requester's stream is ever looked at.
  assign accept   = (state_reg == RUN) && bus.bit_vld[sel_reg];
  assign shifted  = {hist_reg[MAXLEN-2:0], bus.bit_in[sel_reg]};
  assign bcnt_inc = (bcnt_reg == LEN_MAX) ? bcnt_reg : bcnt_reg + LW'(1);
  assign mcnt_inc = (mcnt_reg == CNT_MAX) ? mcnt_reg : mcnt_reg + CNTW'(1);

  // Pointer names the favoured requester; fall back to the other one.
  assign pick = bus.req[ptr_reg] ? ptr_reg : ~ptr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < MAXLEN; gi++) begin : g_mask
      assign len_mask[gi] = (32'(gi) < 32'(len_reg));
    end
  endgenerate

  // A window only counts once at least L bits of this frame have arrived.
  assign hit = (((shifted ^ pat_reg) & len_mask) == '0) && (bcnt_inc >= len_reg);

  always_comb begin
    len_clamped = LW'(1);
    if (bus.cfg_len == 4'd0) begin
      len_clamped = LW'(1);
    end else if (32'(bus.cfg_len) > MAXLEN) begin
      len_clamped = LEN_MAX;
    end else begin
      len_clamped = LW'(bus.cfg_len);
    end
  end

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    sel_next     = sel_reg;
    ptr_next     = ptr_reg;
    hist_next    = hist_reg;
    bcnt_next    = bcnt_reg;
    mcnt_next    = mcnt_reg;
    det_next     = 1'b0;
    res_id_next  = res_id_reg;
    res_cnt_next = res_cnt_reg;
    pat_next     = pat_reg;
    len_next     = len_reg;

    case (state_reg)
      IDLE: begin
        if (bus.cfg_we) begin
          pat_next = bus.cfg_pat;
          len_next = len_clamped;
        end
        if (bus.req != 2'b00) begin
          sel_next   = pick;
          gnt_next   = pick ? 2'b10 : 2'b01;
          hist_next  = '0;
          bcnt_next  = '0;
          mcnt_next  = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        if (accept) begin
          hist_next = shifted;
          bcnt_next = bcnt_inc;
          det_next  = hit;
          if (hit) begin
            mcnt_next = mcnt_inc;
          end
          if (bus.bit_last[sel_reg]) begin
            state_next   = REPORT;
            gnt_next     = 2'b00;
            res_id_next  = sel_reg;
            res_cnt_next = hit ? mcnt_inc : mcnt_reg;
          end
        end
      end

      REPORT: begin
        ptr_next   = ~sel_reg;
        state_next = IDLE;
      end

      default: begin
        gnt_next   = 2'b00;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      gnt_reg     <= 2'b00;
      sel_reg     <= 1'b0;
      ptr_reg     <= 1'b0;
      hist_reg    <= '0;
      bcnt_reg    <= '0;
      mcnt_reg    <= '0;
      det_reg     <= 1'b0;
      res_id_reg  <= 1'b0;
      res_cnt_reg <= '0;
      pat_reg     <= '0;
      len_reg     <= LW'(1);
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      sel_reg     <= sel_next;
      ptr_reg     <= ptr_next;
      hist_reg    <= hist_next;
      bcnt_reg    <= bcnt_next;
      mcnt_reg    <= mcnt_next;
      det_reg     <= det_next;
      res_id_reg  <= res_id_next;
      res_cnt_reg <= res_cnt_next;
      pat_reg     <= pat_next;
      len_reg     <= len_next;
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.det     = det_reg;
  assign bus.res_vld = (state_reg == REPORT);
  assign bus.res_id  = res_id_reg;
  assign bus.res_cnt = res_cnt_reg;
  assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_det_arb.sv
// Bench for seq_det_arb: fixed frame table, hand-built corner sequences and
// random frames checked against a sliding-window reference model.
module tb_seq_det_arb;
  localparam int MAXLEN = 8;
  localparam int CNTW   = 4;
  localparam int CMAX   = (1 << CNTW) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   fav;
  logic [MAXLEN-1:0] cur_pat;
  logic [3:0]        cur_len;

  seq_det_arb_if #(.MAXLEN(MAXLEN), .CNTW(CNTW)) bus ();

  seq_det_arb #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        reqm;
    logic [MAXLEN-1:0] pat;
    logic [3:0]        len;
    logic [63:0]       bits;
    int                n;
    bit                gaps;
    bit                noise;
    logic [63:0]       exp_det;
    int                exp_cnt;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: bit k ends a match when the last L received bits, newest
  // first, equal pattern bits 0..L-1 and at least L bits have arrived.
  function automatic void ref_frame(input logic [MAXLEN-1:0] pat, input logic [3:0] len,
                                    input logic [63:0] bits, input int n,
                                    output logic [63:0] detm, output int cnt);
    int l;
    bit ok;
    l = (len == 4'd0) ? 1 : ((int'(len) > MAXLEN) ? MAXLEN : int'(len));
    detm = '0;
    cnt  = 0;
    for (int k = 0; k < n; k++) begin
      if (k + 1 >= l) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          if (bits[k-j] !== pat[j]) ok = 1'b0;
        end
        if (ok) begin
          detm[k] = 1'b1;
          if (cnt < CMAX) cnt++;
        end
      end
    end
  endfunction

  task automatic drive_idle();
    bus.cfg_we   = 1'b0;
    bus.req      = 2'b00;
    bus.bit_in   = 2'b00;
    bus.bit_vld  = 2'b00;
    bus.bit_last = 2'b00;
  endtask

  // Called and returns on a falling edge with the DUT idle.
  task automatic run_frame(input logic [1:0] reqm, input bit do_cfg,
                           input logic [MAXLEN-1:0] pat, input logic [3:0] len,
                           input logic [63:0] bits, input int n,
                           input bit gaps, input bit noise, input bit cfgnoise,
                           input logic [63:0] exp_det, input int exp_cnt,
                           input string tag);
    int r;
    int o;
    int k;
    int gap_run;
    int guard;
    bit take;
    logic [1:0] eg;
    r  = reqm[fav] ? fav : 1 - fav;
    o  = 1 - r;
    eg = (r == 0) ? 2'b01 : 2'b10;
    bus.cfg_we  = do_cfg;
    bus.cfg_pat = pat;
    bus.cfg_len = len;
    bus.req     = reqm;
    bus.bit_vld = 2'b00;
    bus.bit_last = 2'b00;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    chk({tag, " gnt"}, 32'(bus.gnt), 32'(eg));
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " det_start"}, 32'(bus.det), 32'd0);
    k = 0;
    gap_run = 0;
    guard = 0;
    while (k < n && guard < 400) begin
      guard++;
      take = !(gaps && gap_run < 2 && $urandom_range(0, 2) == 0);
      bus.bit_vld[r]  = take;
      bus.bit_in[r]   = take ? bits[k] : ~bits[k];
      bus.bit_last[r] = take && (k == n - 1);
      if (noise) begin
        bus.bit_vld[o]  = 1'($urandom_range(0, 1));
        bus.bit_in[o]   = 1'($urandom_range(0, 1));
        bus.bit_last[o] = 1'($urandom_range(0, 1));
        bus.req         = 2'($urandom_range(0, 3));
      end else begin
        bus.bit_vld[o]  = 1'b0;
        bus.bit_last[o] = 1'b0;
      end
      if (cfgnoise) begin
        bus.cfg_we  = 1'b1;
        bus.cfg_pat = MAXLEN'($urandom);
        bus.cfg_len = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      if (take) begin
        chk($sformatf("%s det bit%0d", tag, k), 32'(bus.det), 32'(exp_det[k]));
        k++;
        gap_run = 0;
      end else begin
        chk({tag, " det_gap"}, 32'(bus.det), 32'd0);
        gap_run++;
      end
      if (k < n) begin
        chk({tag, " gnt_hold"}, 32'(bus.gnt), 32'(eg));
        chk({tag, " busy_run"}, 32'(bus.busy), 32'd1);
        chk({tag, " res_vld_run"}, 32'(bus.res_vld), 32'd0);
      end
    end
    if (k < n) chk({tag, " bit_budget"}, 32'(k), 32'(n));
    chk({tag, " res_vld"}, 32'(bus.res_vld), 32'd1);
    chk({tag, " res_id"}, 32'(bus.res_id), 32'(r));
    chk({tag, " res_cnt"}, 32'(bus.res_cnt), 32'(exp_cnt));
    chk({tag, " gnt_report"}, 32'(bus.gnt), 32'd0);
    chk({tag, " busy_report"}, 32'(bus.busy), 32'd1);
    drive_idle();
    @(negedge clk);
    chk({tag, " res_vld_drop"}, 32'(bus.res_vld), 32'd0);
    chk({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, " res_cnt_hold"}, 32'(bus.res_cnt), 32'(exp_cnt));
    chk({tag, " res_id_hold"}, 32'(bus.res_id), 32'(r));
    fav = 1 - r;
    $display("frame %s: req=%b granted=%0d bits=%0d count=%0d", tag, reqm, r, n, exp_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]        rq;
    bit                dc;
    logic [MAXLEN-1:0] p;
    logic [3:0]        l;
    logic [63:0]       b;
    int                n;
    logic [63:0]       ed;
    int                ec;

    tbl[0] = '{2'b11, 8'h0B, 4'd4,  64'h1DA,   9,  1'b0, 1'b0, 64'h90,    2};
    tbl[1] = '{2'b11, 8'h01, 4'd1,  64'hFFFFF, 20, 1'b0, 1'b0, 64'hFFFFF, 15};
    tbl[2] = '{2'b01, 8'h01, 4'd0,  64'h3,     2,  1'b0, 1'b1, 64'h3,     2};
    tbl[3] = '{2'b10, 8'hA5, 4'd15, 64'hA5,    8,  1'b1, 1'b0, 64'h80,    1};
    tbl[4] = '{2'b10, 8'h00, 4'd3,  64'h0,     4,  1'b0, 1'b0, 64'hC,     2};
    tbl[5] = '{2'b01, 8'h00, 4'd1,  64'h5,     3,  1'b1, 1'b1, 64'h2,     1};

    checks  = 0;
    errors  = 0;
    fav     = 0;
    cur_pat = '0;
    cur_len = 4'd0;
    clk     = 1'b0;
    reset   = 1'b0;
    bus.cfg_pat = '0;
    bus.cfg_len = 4'd0;
    drive_idle();

    repeat (2) @(negedge clk);
    chk("rst gnt", 32'(bus.gnt), 32'd0);
    chk("rst det", 32'(bus.det), 32'd0);
    chk("rst res_vld", 32'(bus.res_vld), 32'd0);
    chk("rst res_id", 32'(bus.res_id), 32'd0);
    chk("rst res_cnt", 32'(bus.res_cnt), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      cur_pat = tbl[i].pat;
      cur_len = tbl[i].len;
      run_frame(tbl[i].reqm, 1'b1, tbl[i].pat, tbl[i].len, tbl[i].bits, tbl[i].n,
                tbl[i].gaps, tbl[i].noise, 1'b0, tbl[i].exp_det, tbl[i].exp_cnt,
                $sformatf("tbl%0d", i));
    end

    // Configuration writes during a frame must not disturb it.
    cur_pat = 8'h0B;
    cur_len = 4'd4;
    run_frame(2'b01, 1'b1, 8'h0B, 4'd4, 64'h1DA, 9, 1'b0, 1'b0, 1'b1, 64'h90, 2, "cfg_run");
    run_frame(2'b10, 1'b0, 8'h00, 4'd0, 64'h1DA, 9, 1'b0, 1'b0, 1'b0, 64'h90, 2, "cfg_kept");

    // Asynchronous reset in the middle of a frame.
    bus.req = 2'b01;
    @(negedge clk);
    chk("mid gnt", 32'(bus.gnt), 32'd1);
    bus.req     = 2'b00;
    bus.bit_vld = 2'b01;
    bus.bit_in  = 2'b01;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid rst gnt", 32'(bus.gnt), 32'd0);
    chk("mid rst busy", 32'(bus.busy), 32'd0);
    chk("mid rst det", 32'(bus.det), 32'd0);
    chk("mid rst res_cnt", 32'(bus.res_cnt), 32'd0);
    chk("mid rst res_id", 32'(bus.res_id), 32'd0);
    drive_idle();
    @(negedge clk);
    chk("mid rst res_vld", 32'(bus.res_vld), 32'd0);
    reset   = 1'b1;
    fav     = 0;
    cur_pat = '0;
    cur_len = 4'd0;
    @(negedge clk);
    chk("post rst res_vld", 32'(bus.res_vld), 32'd0);
    chk("post rst busy", 32'(bus.busy), 32'd0);
    $display("frame mid_reset: aborted after 2 bits");
    run_frame(2'b11, 1'b0, 8'h00, 4'd0, 64'h0, 2, 1'b0, 1'b0, 1'b0, 64'h3, 2, "post_rst");

    for (int i = 0; i < 40; i++) begin
      rq = 2'($urandom_range(1, 3));
      dc = ($urandom_range(0, 2) != 0);
      p  = MAXLEN'($urandom);
      l  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      b  = {$urandom, $urandom};
      if ($urandom_range(0, 1) != 0) b = b & {$urandom, $urandom};
      n  = $urandom_range(1, 24);
      if (dc) begin
        cur_pat = p;
        cur_len = l;
      end
      ref_frame(cur_pat, cur_len, b, n, ed, ec);
      run_frame(rq, dc, p, l, b, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ed, ec, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
